// File: rtl/fpu_mult_ctrl.sv
// fpu_mult_ctrl: register-mapped front end for the half-precision multiplier.
// Holds the operands, issues one operation at a time to fpu_mult, captures the
// result with a classification, and reports done/timeout/write-error status
// with an optional completion interrupt.
module fpu_mult_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt,
  output logic [15:0] mult_a,
  output logic [15:0] mult_b,
  output logic        mult_valid_in,
  input  logic        mult_valid_out,
  input  logic [15:0] mult_result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  localparam logic [5:0] ADDR_OPA    = 6'h00;
  localparam logic [5:0] ADDR_OPB    = 6'h04;
  localparam logic [5:0] ADDR_CTRL   = 6'h08;
  localparam logic [5:0] ADDR_RESULT = 6'h0C;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic [15:0] result_q, result_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        timeout_err_q, timeout_err_d;
  logic        write_err_q, write_err_d;
  logic        irq_q, irq_d;

  logic        wr_en;
  logic        wr_byte;
  logic        rd_result;
  logic        busy;
  logic        ctrl_start;
  logic        ctrl_clr;
  logic [15:0] wr_merge_opa;
  logic [15:0] wr_merge_opb;

  logic        res_nan, res_inf, res_zero, res_sub;

  // Upper write-data bits never reach any register.
  logic        unused_data_hi;
  assign unused_data_hi = ^data_in[31:16];

  assign data_ready     = 1'b1;
  assign user_interrupt = irq_q;
  assign mult_a         = opa_q;
  assign mult_b         = opb_q;
  assign mult_valid_in  = (state_q == S_ISSUE);

  // Bus decode: write strobes, write-data merge and START/CLR extraction.
  always_comb begin
    wr_en        = (data_write_n != 2'b11);
    wr_byte      = (data_write_n == 2'b00);
    rd_result    = (data_read_n != 2'b11) && (address == ADDR_RESULT);
    busy         = (state_q != S_IDLE);
    ctrl_start   = wr_en && (address == ADDR_CTRL) && data_in[0];
    ctrl_clr     = wr_en && (address == ADDR_CTRL) && data_in[2];
    wr_merge_opa = wr_byte ? {opa_q[15:8], data_in[7:0]} : data_in[15:0];
    wr_merge_opb = wr_byte ? {opb_q[15:8], data_in[7:0]} : data_in[15:0];
  end

  // Classification of the stored result as seen through the RESULT register.
  always_comb begin
    res_nan  = (result_q[14:10] == 5'h1F) && (result_q[9:0] != 10'd0);
    res_inf  = (result_q[14:10] == 5'h1F) && (result_q[9:0] == 10'd0);
    res_zero = (result_q[14:10] == 5'h00) && (result_q[9:0] == 10'd0);
    res_sub  = (result_q[14:10] == 5'h00) && (result_q[9:0] != 10'd0);
  end

  // Next-state logic: clears first, then bus writes, then the FSM so that a
  // completion in the same cycle overrides a clear or a RESULT read.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    result_d      = result_q;
    irq_en_d      = irq_en_q;
    done_d        = done_q;
    timeout_err_d = timeout_err_q;
    write_err_d   = write_err_q;
    irq_d         = irq_q;

    if (ctrl_clr) begin
      done_d        = 1'b0;
      timeout_err_d = 1'b0;
      write_err_d   = 1'b0;
      irq_d         = 1'b0;
    end

    if (rd_result) begin
      done_d = 1'b0;
      irq_d  = 1'b0;
    end

    if (wr_en && (address == ADDR_CTRL)) begin
      irq_en_d = data_in[1];
    end

    if (ctrl_start) begin
      if (busy) begin
        write_err_d = 1'b1;
      end else begin
        done_d        = 1'b0;
        timeout_err_d = 1'b0;
        state_d       = S_ISSUE;
      end
    end

    if (wr_en && ((address == ADDR_OPA) || (address == ADDR_OPB))) begin
      if (busy) begin
        write_err_d = 1'b1;
      end else if (address == ADDR_OPA) begin
        opa_d = wr_merge_opa;
      end else begin
        opb_d = wr_merge_opb;
      end
    end

    case (state_q)
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = 8'd1;
      end
      S_WAIT: begin
        if (mult_valid_out) begin
          state_d  = S_IDLE;
          cnt_d    = 8'd0;
          result_d = mult_result;
          done_d   = 1'b1;
          if (irq_en_q) irq_d = 1'b1;
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d       = S_IDLE;
          cnt_d         = 8'd0;
          timeout_err_d = 1'b1;
          done_d        = 1'b0;
          if (irq_en_q) irq_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d = 8'd0;
      end
    endcase
  end

  // Register read mux, combinational from the address.
  always_comb begin
    data_out = 32'd0;
    case (address)
      ADDR_OPA:    data_out = {16'd0, opa_q};
      ADDR_OPB:    data_out = {16'd0, opb_q};
      ADDR_CTRL:   data_out = {27'd0, irq_en_q, write_err_q, timeout_err_q, done_q, busy};
      ADDR_RESULT: data_out = {12'd0, res_sub, res_zero, res_inf, res_nan, result_q};
      default:     data_out = 32'd0;
    endcase
  end

  // State and register file, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      opa_q         <= 16'd0;
      opb_q         <= 16'd0;
      result_q      <= 16'd0;
      irq_en_q      <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      write_err_q   <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      result_q      <= result_d;
      irq_en_q      <= irq_en_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      write_err_q   <= write_err_d;
      irq_q         <= irq_d;
    end
  end

endmodule

// File: tb/tb_fpu_mult_ctrl.sv
// Testbench for fpu_mult_ctrl: a stub multiplier answers with bench-chosen
// results after a programmable latency; expected RESULT words go into a
// scoreboard queue at issue time and are compared when read back.
module tb_fpu_mult_ctrl;

  logic        clk;
  logic        rst_n;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;
  logic [15:0] mult_a;
  logic [15:0] mult_b;
  logic        mult_valid_in;
  logic        mult_valid_out;
  logic [15:0] mult_result;

  logic        auto_valid;
  logic [15:0] auto_result;
  logic        manual_valid;
  logic [15:0] manual_result;

  logic        stub_enable;
  int          stub_lat;
  logic [15:0] stub_val;
  logic        pend;
  int          pend_cnt;
  logic [15:0] pend_val;
  int          pulse_cnt;
  logic [15:0] seen_a;
  logic [15:0] seen_b;

  int          total_cnt;
  int          pass_cnt;
  logic [31:0] sb_q[$];
  logic [31:0] last_result;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] prod;
    int          lat;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[8];

  assign mult_valid_out = auto_valid | manual_valid;
  assign mult_result    = manual_valid ? manual_result : auto_result;

  fpu_mult_ctrl #(.TIMEOUT(15)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt),
    .mult_a         (mult_a),
    .mult_b         (mult_b),
    .mult_valid_in  (mult_valid_in),
    .mult_valid_out (mult_valid_out),
    .mult_result    (mult_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub multiplier: latches the request on the issue strobe and answers
  // after stub_lat cycles, driving its outputs on the falling edge.
  initial begin
    auto_valid  = 1'b0;
    auto_result = 16'd0;
    pend        = 1'b0;
    pend_cnt    = 0;
    pend_val    = 16'd0;
    pulse_cnt   = 0;
    seen_a      = 16'd0;
    seen_b      = 16'd0;
    forever begin
      @(negedge clk);
      auto_valid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          pend_cnt = pend_cnt - 1;
          if (pend_cnt == 0) begin
            auto_valid  = 1'b1;
            auto_result = pend_val;
            pend        = 1'b0;
          end
        end
        if (mult_valid_in) begin
          pulse_cnt = pulse_cnt + 1;
          seen_a    = mult_a;
          seen_b    = mult_b;
          if (stub_enable) begin
            pend     = 1'b1;
            pend_cnt = stub_lat;
            pend_val = stub_val;
          end
        end
      end
    end
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    if (act === exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Bus accesses start and end on a falling edge and span one rising edge.
  task automatic bus_write(input logic [5:0] addr, input logic [31:0] data, input logic [1:0] size);
    address      = addr;
    data_in      = data;
    data_write_n = size;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [5:0] addr, output logic [31:0] data);
    address     = addr;
    data_read_n = 2'b00;
    #1;
    data = data_out;
    @(negedge clk);
    data_read_n = 2'b11;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    address = 6'h08;
    #1;
    while (data_out[0] && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput(name, 32'(n < 60), 32'd1);
  endtask

  task automatic read_and_score(input string name);
    logic [31:0] rd;
    logic [31:0] exp;
    bus_read(6'h0C, rd);
    if (sb_q.size() == 0) begin
      checkOutput({name, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
    end else begin
      exp = sb_q.pop_front();
      last_result = exp;
      checkOutput(name, rd, exp);
    end
  endtask

  // Loads operands, issues with IRQ_EN and records the expected RESULT word.
  task automatic applyStimulus(input vec_t v, input int idx);
    int p0;
    stub_enable = 1'b1;
    stub_lat    = v.lat;
    stub_val    = v.prod;
    bus_write(6'h00, {16'hDEAD, v.a}, 2'b01);
    bus_write(6'h04, {16'hBEEF, v.b}, 2'b10);
    p0 = pulse_cnt;
    bus_write(6'h08, 32'h3, 2'b10);
    checkOutput($sformatf("vec%0d_issue_strobe", idx), 32'(mult_valid_in), 32'd1);
    sb_q.push_back(v.exp_res);
    @(negedge clk);
    checkOutput($sformatf("vec%0d_strobe_one_cycle", idx), 32'(mult_valid_in), 32'd0);
    wait_idle($sformatf("vec%0d_wait", idx));
    checkOutput($sformatf("vec%0d_pulses", idx), 32'(pulse_cnt - p0), 32'd1);
    checkOutput($sformatf("vec%0d_operands", idx), {seen_a, seen_b}, {v.a, v.b});
  endtask

  initial begin
    logic [31:0] rd;
    int          n;
    int          p0;

    total_cnt     = 0;
    pass_cnt      = 0;
    last_result   = 32'd0;
    rst_n         = 1'b0;
    address       = 6'h00;
    data_in       = 32'd0;
    data_write_n  = 2'b11;
    data_read_n   = 2'b11;
    manual_valid  = 1'b0;
    manual_result = 16'd0;
    stub_enable   = 1'b0;
    stub_lat      = 1;
    stub_val      = 16'd0;

    vecs[0] = '{16'h4000, 16'h4200, 16'h4600, 1, 32'h0000_4600};
    vecs[1] = '{16'h7C00, 16'h4000, 16'h7C00, 3, 32'h0002_7C00};
    vecs[2] = '{16'h0000, 16'h3C00, 16'h0000, 2, 32'h0004_0000};
    vecs[3] = '{16'h7E00, 16'h3C00, 16'h7E00, 4, 32'h0001_7E00};
    vecs[4] = '{16'h0001, 16'h3C00, 16'h0001, 2, 32'h0008_0001};
    vecs[5] = '{16'h3C00, 16'h3C00, 16'h3C00, 6, 32'h0000_3C00};
    vecs[6] = '{16'hFC00, 16'h3C00, 16'hFC00, 1, 32'h0002_FC00};
    vecs[7] = '{16'h7C01, 16'h8000, 16'h7C01, 5, 32'h0001_7C01};

    // Reset values
    repeat (3) @(negedge clk);
    address = 6'h08;
    #1;
    checkOutput("rst_status", data_out, 32'd0);
    checkOutput("rst_irq", 32'(user_interrupt), 32'd0);
    checkOutput("rst_valid_in", 32'(mult_valid_in), 32'd0);
    checkOutput("rst_operands", {mult_a, mult_b}, 32'd0);
    checkOutput("data_ready", 32'(data_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(6'h0C, rd);
    checkOutput("rst_result", rd, 32'h0004_0000);

    // Byte/half/word write widths and unmapped addresses
    bus_write(6'h00, 32'h0000_4000, 2'b01);
    bus_write(6'h00, 32'h0000_00AB, 2'b00);
    bus_read(6'h00, rd);
    checkOutput("byte_write_opa", rd, 32'h0000_40AB);
    checkOutput("mult_a_follows", 32'(mult_a), 32'h0000_40AB);
    bus_write(6'h04, 32'hFFFF_1234, 2'b10);
    bus_read(6'h04, rd);
    checkOutput("word_write_opb", rd, 32'h0000_1234);
    bus_write(6'h10, 32'hFFFF_FFFF, 2'b10);
    bus_read(6'h10, rd);
    checkOutput("unmapped_read", rd, 32'd0);

    // Table-driven operations through the stub multiplier
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], i);
      checkOutput($sformatf("vec%0d_irq", i), 32'(user_interrupt), 32'd1);
      bus_read(6'h08, rd);
      checkOutput($sformatf("vec%0d_status_done", i), rd, 32'h12);
      read_and_score($sformatf("vec%0d_result", i));
      bus_read(6'h08, rd);
      checkOutput($sformatf("vec%0d_status_cleared", i), rd, 32'h10);
      checkOutput($sformatf("vec%0d_irq_cleared", i), 32'(user_interrupt), 32'd0);
    end

    // Busy protection: operand and START writes during an operation
    stub_enable = 1'b1;
    stub_lat    = 10;
    stub_val    = 16'h4500;
    bus_write(6'h00, 32'h0000_4000, 2'b01);
    p0 = pulse_cnt;
    bus_write(6'h08, 32'h1, 2'b10);
    sb_q.push_back(32'h0000_4500);
    bus_write(6'h00, 32'h0000_1234, 2'b01);
    bus_write(6'h08, 32'h1, 2'b10);
    bus_read(6'h08, rd);
    checkOutput("busy_status", rd, 32'h09);
    bus_read(6'h00, rd);
    checkOutput("busy_opa_kept", rd, 32'h0000_4000);
    wait_idle("busy_wait");
    checkOutput("busy_single_pulse", 32'(pulse_cnt - p0), 32'd1);
    read_and_score("busy_result");
    bus_read(6'h08, rd);
    checkOutput("busy_werr_sticky", rd, 32'h08);
    bus_write(6'h08, 32'h4, 2'b10);
    bus_read(6'h08, rd);
    checkOutput("clr_status", rd, 32'h00);

    // Timeout: multiplier never answers
    stub_enable = 1'b0;
    bus_write(6'h08, 32'h3, 2'b10);
    n = 0;
    while (data_out[0] && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("timeout_busy_cycles", 32'(n), 32'd16);
    checkOutput("timeout_irq", 32'(user_interrupt), 32'd1);
    bus_read(6'h08, rd);
    checkOutput("timeout_status", rd, 32'h14);
    bus_read(6'h0C, rd);
    checkOutput("timeout_result_kept", rd, last_result);
    checkOutput("timeout_irq_read_clr", 32'(user_interrupt), 32'd0);
    manual_result = 16'h5555;
    manual_valid  = 1'b1;
    @(negedge clk);
    manual_valid  = 1'b0;
    bus_read(6'h08, rd);
    checkOutput("stray_valid_status", rd, 32'h14);
    bus_read(6'h0C, rd);
    checkOutput("stray_valid_result", rd, last_result);

    // Completion on the very edge the counter reaches TIMEOUT
    bus_write(6'h08, 32'h3, 2'b10);
    repeat (15) @(negedge clk);
    manual_result = 16'h4400;
    manual_valid  = 1'b1;
    sb_q.push_back(32'h0000_4400);
    @(negedge clk);
    manual_valid  = 1'b0;
    bus_read(6'h08, rd);
    checkOutput("edge_done_status", rd, 32'h12);
    read_and_score("edge_result");

    // Completion and RESULT read on the same edge
    bus_write(6'h08, 32'h3, 2'b10);
    repeat (3) @(negedge clk);
    manual_result = 16'h3800;
    manual_valid  = 1'b1;
    address       = 6'h0C;
    data_read_n   = 2'b00;
    sb_q.push_back(32'h0000_3800);
    @(negedge clk);
    manual_valid  = 1'b0;
    data_read_n   = 2'b11;
    checkOutput("race_irq_kept", 32'(user_interrupt), 32'd1);
    bus_read(6'h08, rd);
    checkOutput("race_done_kept", rd, 32'h12);
    read_and_score("race_result");
    bus_read(6'h08, rd);
    checkOutput("race_done_cleared", rd, 32'h10);

    // Reset in the middle of WAIT, then a late answer
    bus_write(6'h08, 32'h3, 2'b10);
    repeat (3) @(negedge clk);
    rst_n   = 1'b0;
    address = 6'h08;
    #1;
    checkOutput("midrst_status", data_out, 32'd0);
    checkOutput("midrst_irq", 32'(user_interrupt), 32'd0);
    checkOutput("midrst_valid_in", 32'(mult_valid_in), 32'd0);
    checkOutput("midrst_operands", {mult_a, mult_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    manual_result = 16'h4000;
    manual_valid  = 1'b1;
    @(negedge clk);
    manual_valid  = 1'b0;
    bus_read(6'h08, rd);
    checkOutput("late_valid_status", rd, 32'd0);
    bus_read(6'h0C, rd);
    checkOutput("late_valid_result", rd, 32'h0004_0000);

    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
